// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    localparam int unsigned MEM_LAT_MAX = 7;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker; bit 0 is fetch, bit 1 is data.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // last = 1 means data won the previous grant, so fetch wins a tie
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory between fetch and data ports,
// with a single outstanding transaction and re-arbitration in the response cycle.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                m_en,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

    if (MEM_LAT == 0 || MEM_LAT > MEM_LAT_MAX) begin : g_lat_check
        $fatal(1, "mem_arbiter: MEM_LAT=%0d outside 1..%0d", MEM_LAT, MEM_LAT_MAX);
    end

    if (DATA_W == 0 || (DATA_W % 8) != 0) begin : g_width_check
        $fatal(1, "mem_arbiter: DATA_W=%0d is not a multiple of 8", DATA_W);
    end

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_d_q, last_d_d;
    req_id_t           owner_q, owner_d;

    logic              resp;
    logic              can_grant;
    logic [1:0]        req_vec;
    logic [1:0]        pick;
    logic              gnt_i;
    logic              gnt_d;

    assign resp      = (state_q == BUSY) && (cnt_q == CNT_W'(1));
    // Reset gating keeps grants off while reset is held, even with requests present
    assign can_grant = reset && ((state_q == IDLE) || resp);
    assign req_vec   = {d_req, i_req};

    rr_arb2 u_rr_arb2 (
        .req  (req_vec),
        .last (last_d_q),
        .gnt  (pick)
    );

    assign gnt_i = can_grant && pick[0];
    assign gnt_d = can_grant && pick[1];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d_d = last_d_q;
        owner_d  = owner_q;
        if (gnt_i || gnt_d) begin
            state_d  = BUSY;
            cnt_d    = CNT_W'(MEM_LAT);
            last_d_d = gnt_d;
            owner_d  = gnt_d ? REQ_D : REQ_I;
        end else if (state_q == BUSY) begin
            if (resp) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_d_q <= 1'b0;
            owner_q  <= REQ_I;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_d_q <= last_d_d;
            owner_q  <= owner_d;
        end
    end

    always_comb begin
        i_gnt   = gnt_i;
        d_gnt   = gnt_d;
        m_en    = gnt_i || gnt_d;
        m_we    = gnt_d && d_we;
        m_be    = '0;
        m_addr  = '0;
        m_wdata = '0;
        if (gnt_d) begin
            m_addr  = d_addr;
            m_be    = d_we ? d_be : '1;
            m_wdata = d_we ? d_wdata : '0;
        end else if (gnt_i) begin
            m_addr = i_addr;
            m_be   = '1;
        end
    end

    assign i_rvalid = resp && (owner_q == REQ_I);
    assign d_rvalid = resp && (owner_q == REQ_D);
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

    a_gnt_onehot : assert property (@(posedge clk) disable iff (!reset) !(i_gnt && d_gnt));
    a_rvalid_onehot : assert property (@(posedge clk) disable iff (!reset)
                                       !(i_rvalid && d_rvalid));

endmodule
